// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin bus arbiter with a locked grant and a watchdog that
// returns an error word when the slave never completes.
module bus_arbiter_2m #(
  parameter int            N        = 32,
  parameter int            TIMEOUT  = 64,
  parameter logic [N-1:0]  ERR_DATA = N'(32'hDEADBEEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         m0_req,
  input  logic [N-1:0] m0_addr,
  input  logic         m0_cmd,
  input  logic [N-1:0] m0_wdata,
  output logic         m0_ack,
  output logic [N-1:0] m0_rdata,
  input  logic         m1_req,
  input  logic [N-1:0] m1_addr,
  input  logic         m1_cmd,
  input  logic [N-1:0] m1_wdata,
  output logic         m1_ack,
  output logic [N-1:0] m1_rdata,
  output logic         bus_req,
  output logic [N-1:0] bus_addr,
  output logic         bus_cmd,
  output logic [N-1:0] bus_wdata,
  input  logic         bus_ack,
  input  logic [N-1:0] bus_rdata,
  output logic         timeout_err
);

  localparam bit             WD_EN   = (TIMEOUT > 0);
  localparam int             WDW     = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WD_EN ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [WDW-1:0] WD_MAX  = WD_EN ? WDW'(TIMEOUT) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state;
  logic           gnt;
  logic           rr_last;
  logic [WDW-1:0] wd_cnt;

  logic           busy;
  logic           g_req;
  logic           g_cmd;
  logic [N-1:0]   g_addr;
  logic [N-1:0]   g_wdata;
  logic           done_ok;
  logic           done_to;
  logic           viol;
  logic           pick;

  // Granted-master mux, completion/timeout/violation detection, next-grant pick
  always_comb begin
    busy = (state == BUSY);
    if (gnt) begin
      g_req   = m1_req;
      g_cmd   = m1_cmd;
      g_addr  = m1_addr;
      g_wdata = m1_wdata;
    end else begin
      g_req   = m0_req;
      g_cmd   = m0_cmd;
      g_addr  = m0_addr;
      g_wdata = m0_wdata;
    end
    done_ok = busy && g_req && bus_ack;
    // a same-cycle bus_ack beats the watchdog
    done_to = WD_EN && busy && g_req && !bus_ack && (wd_cnt == WD_LAST);
    viol    = busy && !g_req;
    if (m0_req && m1_req) begin
      pick = ~rr_last;
    end else if (m1_req) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
  end

  // Arbiter FSM: grant lock, round-robin history and saturating watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      rr_last <= 1'b1;
      wd_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt    <= pick;
            state  <= BUSY;
            wd_cnt <= '0;
          end else begin
            state  <= IDLE;
          end
        end
        BUSY: begin
          if (done_ok || done_to || viol) begin
            state   <= IDLE;
            rr_last <= gnt;
          end else if (WD_EN && (wd_cnt != WD_MAX)) begin
            wd_cnt  <= wd_cnt + 1'b1;
          end else begin
            wd_cnt  <= wd_cnt;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus-side and master-side outputs; reset blanks them in the same cycle
  always_comb begin
    bus_req     = 1'b0;
    bus_addr    = '0;
    bus_cmd     = 1'b0;
    bus_wdata   = '0;
    m0_ack      = 1'b0;
    m0_rdata    = '0;
    m1_ack      = 1'b0;
    m1_rdata    = '0;
    timeout_err = 1'b0;
    if (!rst && busy) begin
      bus_req     = g_req && !done_to;
      bus_addr    = g_addr;
      bus_cmd     = g_cmd;
      bus_wdata   = g_wdata;
      timeout_err = done_to;
      if (done_ok || done_to) begin
        if (gnt) begin
          m1_ack   = 1'b1;
          m1_rdata = done_to ? ERR_DATA : bus_rdata;
        end else begin
          m0_ack   = 1'b1;
          m0_rdata = done_to ? ERR_DATA : bus_rdata;
        end
      end else begin
        m0_ack = 1'b0;
        m1_ack = 1'b0;
      end
    end else begin
      bus_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Randomized bench for bus_arbiter_2m: master agents, a slave whose behaviour is
// keyed on the address, a transaction-level model and a scoreboard on the acks.
module tb_bus_arbiter_2m;

  localparam int          N   = 32;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  localparam logic [31:0] KEY = 32'h1234_5678;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         m0_req, m0_cmd, m0_ack, m1_req, m1_cmd, m1_ack;
  logic [N-1:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic         bus_req, bus_cmd, bus_ack, timeout_err;
  logic [N-1:0] bus_addr, bus_wdata, bus_rdata;

  bus_arbiter_2m #(.N(N), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_cmd(bus_cmd), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;

  // master agent state, one entry per master
  logic        req   [2];
  logic        cmd   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        nev   [2];
  int          dly   [2];
  int          gap   [2];
  logic        got   [2];

  // transaction-level model of the shared bus
  bit mbusy;
  bit mg;
  bit mlast;
  int age;

  assign m0_req = req[0];  assign m0_cmd = cmd[0];
  assign m0_addr = addr[0]; assign m0_wdata = wdata[0];
  assign m1_req = req[1];  assign m1_cmd = cmd[1];
  assign m1_addr = addr[1]; assign m1_wdata = wdata[1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // new transaction: address bits pick slave latency or a dead slave
  task automatic raise(input int m);
    exp_t e;
    req[m]   = 1'b1;
    cmd[m]   = 1'($urandom_range(0, 1));
    wdata[m] = $urandom;
    addr[m]  = $urandom;
    nev[m]   = ($urandom_range(0, 5) == 0);
    if (nev[m]) addr[m][7:4] = 4'hE;
    else if (addr[m][7:4] == 4'hE) addr[m][7:4] = 4'h1;
    dly[m]   = int'(addr[m][1:0]);
    e.rdata  = nev[m] ? ERR : (addr[m] ^ KEY);
    e.to     = nev[m];
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // one bus cycle, entered and left at posedge+1
  task automatic step(input bit en);
    bit exp_req;
    bit done;
    for (int m = 0; m < 2; m++) begin
      if (req[m] && got[m]) begin
        req[m] = 1'b0; got[m] = 1'b0; gap[m] = $urandom_range(0, 3);
      end else if (!req[m]) begin
        if (gap[m] == 0) begin
          if (en) raise(m);
        end else begin
          gap[m]--;
        end
      end
    end
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    exp_req   = 1'b0;
    done      = 1'b0;
    if (mbusy) begin
      if (!nev[mg] && age == dly[mg]) begin
        bus_ack = 1'b1; bus_rdata = addr[mg] ^ KEY; done = 1'b1; exp_req = 1'b1;
      end else if (age == TO - 1) begin
        done = 1'b1;
      end else begin
        exp_req = 1'b1;
      end
      age++;
    end
    #1;
    chk("bus_req", 32'(bus_req), 32'(exp_req));
    if (mbusy) begin
      chk("bus_addr", bus_addr, addr[mg]);
      chk("bus_cmd", 32'(bus_cmd), 32'(cmd[mg]));
      chk("bus_wdata", bus_wdata, wdata[mg]);
    end else begin
      chk("idle_bus_addr", bus_addr, 32'd0);
    end
    if (mbusy) begin
      if (done) begin
        mbusy = 1'b0; mlast = mg; got[mg] = 1'b1;
      end
    end else if (req[0] || req[1]) begin
      mg    = (req[0] && req[1]) ? ~mlast : req[1];
      mbusy = 1'b1;
      age   = 0;
    end
    @(posedge clk); #1;
  endtask

  // scoreboard monitor: every master ack is matched against its queue
  always @(negedge clk) begin
    exp_t e;
    if (m0_ack) begin
      if (q0.size() == 0) chk("m0_unexpected_ack", 32'(m0_ack), 32'd0);
      else begin
        e = q0.pop_front();
        chk("m0_rdata", m0_rdata, e.rdata);
        chk("m0_timeout_err", 32'(timeout_err), 32'(e.to));
      end
    end else begin
      chk("m0_rdata_idle", m0_rdata, 32'd0);
    end
    if (m1_ack) begin
      if (q1.size() == 0) chk("m1_unexpected_ack", 32'(m1_ack), 32'd0);
      else begin
        e = q1.pop_front();
        chk("m1_rdata", m1_rdata, e.rdata);
        chk("m1_timeout_err", 32'(timeout_err), 32'(e.to));
      end
    end else begin
      chk("m1_rdata_idle", m1_rdata, 32'd0);
    end
    if (timeout_err) begin
      chk("timeout_needs_ack", 32'(m0_ack | m1_ack), 32'd1);
      chk("timeout_bus_req", 32'(bus_req), 32'd0);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((mbusy || req[0] || req[1]) && n < 200) begin
      step(1'b0);
      n++;
    end
    chk("drain_done", 32'(mbusy | req[0] | req[1]), 32'd0);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; cmd[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
      nev[m] = 1'b0; dly[m] = 0; gap[m] = 0; got[m] = 1'b0;
    end
    bus_ack = 1'b0; bus_rdata = '0;
    mbusy = 1'b0; mg = 1'b0; mlast = 1'b1; age = 0;

    // both masters request during reset, so both are pending on the first free cycle
    raise(0);
    raise(1);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_bus_req", 32'(bus_req), 32'd0);
    chk("reset_m0_ack", 32'(m0_ack), 32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (600) step(1'b1);
    drain();

    // reset while a transaction is in flight; it must never be acked
    req[0] = 1'b1; addr[0] = 32'h0000_00E0; cmd[0] = 1'b1; wdata[0] = 32'h1111_2222;
    @(posedge clk); #2;
    chk("rst_pre_bus_req", 32'(bus_req), 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
    chk("rst_mid_bus_addr", bus_addr, 32'd0);
    chk("rst_mid_bus_cmd", 32'(bus_cmd), 32'd0);
    chk("rst_mid_bus_wdata", bus_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req[0] = 1'b0;
    req[1] = 1'b1; addr[1] = 32'h8000_0004; cmd[1] = 1'b1; wdata[1] = 32'hCAFE_F00D;
    q1.push_back('{rdata: 32'h8000_0004 ^ KEY, to: 1'b0});
    #1;
    chk("post_rst_bubble", 32'(bus_req), 32'd0);
    @(posedge clk); #2;
    chk("post_rst_bus_req", 32'(bus_req), 32'd1);
    chk("m1_write_addr", bus_addr, 32'h8000_0004);
    chk("m1_write_cmd", 32'(bus_cmd), 32'd1);
    chk("m1_write_wdata", bus_wdata, 32'hCAFE_F00D);
    bus_ack = 1'b1; bus_rdata = 32'h8000_0004 ^ KEY;
    @(posedge clk); #1;
    bus_ack = 1'b0; req[1] = 1'b0;
    #1;
    chk("post_ack_idle", 32'(bus_req), 32'd0);
    @(posedge clk); #1;

    // granted master abandons its request; a late bus_ack must be ignored
    req[0] = 1'b1; addr[0] = 32'h0000_00E0;
    @(posedge clk); #2;
    chk("viol_pre_bus_req", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0; #1;
    chk("viol_drop_bus_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA; #1;
    chk("late_ack_m0_ack", 32'(m0_ack), 32'd0);
    chk("late_ack_bus_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;

    // m0 was served last, so a simultaneous request pair must go to m1 first
    mbusy = 1'b0; mlast = 1'b0;
    gap[0] = 0; gap[1] = 0; got[0] = 1'b0; got[1] = 1'b0;
    repeat (300) step(1'b1);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
